// File: rtl/wb_regfile_writeback_if.sv
// MEM/WB-to-writeback bus: pipeline slot inputs, decode read ports and writeback status.
// The master modport is the pipeline/decode side and the slave modport is the writeback stage.
interface wb_regfile_writeback_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  // retire_valid qualifies the MEM/WB slot and stall freezes it; there is no
  // back-pressure, so the slot is consumed exactly once, on the first edge
  // where retire_valid=1 and stall=0.
  logic             stall;
  logic             retire_valid;
  logic [XLEN-1:0]  ram_data;
  logic [XLEN-1:0]  alu_rd_result;
  logic [XLEN-1:0]  next_pc_data;
  logic [4:0]       rd_address;
  logic [1:0]       reg_write_data_src;
  logic             reg_write_enable;
  logic [4:0]       rs1_address;
  logic [4:0]       rs2_address;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  wb_data;
  logic             wb_commit;
  logic [CNT_W-1:0] instret;
  logic             illegal_src;

  modport master (
    output stall, retire_valid, ram_data, alu_rd_result, next_pc_data,
           rd_address, reg_write_data_src, reg_write_enable,
           rs1_address, rs2_address,
    input  rs1_data, rs2_data, wb_data, wb_commit, instret, illegal_src
  );

  modport slave (
    input  stall, retire_valid, ram_data, alu_rd_result, next_pc_data,
           rd_address, reg_write_data_src, reg_write_enable,
           rs1_address, rs2_address,
    output rs1_data, rs2_data, wb_data, wb_commit, instret, illegal_src
  );
endinterface

// File: rtl/wb_regfile_writeback.sv
// Writeback stage: selects the writeback value, commits it to the 32x32 register file,
// serves two async read ports, counts retirements and flags illegal sources. Option: WB_WRITE_THROUGH_EN.
module wb_regfile_writeback #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 64
) (
  input logic                  clk,
  input logic                  reset_n,
  wb_regfile_writeback_if.slave bus
);

  typedef enum logic [1:0] {
    SRC_ALU     = 2'b00,
    SRC_RAM     = 2'b01,
    SRC_PC      = 2'b10,
    SRC_ILLEGAL = 2'b11
  } wb_src_e;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;
  logic             illegal_src_q;
  logic             illegal_src_d;

  logic             retire;
  logic             src_illegal;
  logic             wb_commit;
  logic [XLEN-1:0]  wb_data;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;

  assign retire      = bus.retire_valid & ~bus.stall;
  assign src_illegal = (bus.reg_write_data_src == SRC_ILLEGAL);
  assign wb_commit   = bus.reg_write_enable & retire &
                       (bus.rd_address != 5'd0) & ~src_illegal;

  always_comb begin
    wb_data = '0;
    case (bus.reg_write_data_src)
      SRC_ALU: wb_data = bus.alu_rd_result;
      SRC_RAM: wb_data = bus.ram_data;
      SRC_PC:  wb_data = bus.next_pc_data;
      default: wb_data = '0;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_commit) begin
      regs_d[bus.rd_address] = wb_data;
    end
  end

  // Stores, branches and bubbles-with-valid all count; only stall and bubbles do not.
  always_comb begin
    instret_d = instret_q;
    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    illegal_src_d = illegal_src_q;
    if (bus.reg_write_enable & retire & src_illegal) begin
      illegal_src_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      regs_q        <= '{default: '0};
      instret_q     <= '0;
      illegal_src_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      instret_q     <= instret_d;
      illegal_src_q <= illegal_src_d;
    end
  end

  // x0 reads as zero regardless of storage; the bypass only fires on a real commit,
  // so it can never return a value for x0.
  always_comb begin
    rs1_data = '0;
    if (bus.rs1_address != 5'd0) begin
      rs1_data = regs_q[bus.rs1_address];
    end
`ifdef WB_WRITE_THROUGH_EN
    if (wb_commit && (bus.rs1_address == bus.rd_address)) begin
      rs1_data = wb_data;
    end
`endif
  end

  always_comb begin
    rs2_data = '0;
    if (bus.rs2_address != 5'd0) begin
      rs2_data = regs_q[bus.rs2_address];
    end
`ifdef WB_WRITE_THROUGH_EN
    if (wb_commit && (bus.rs2_address == bus.rd_address)) begin
      rs2_data = wb_data;
    end
`endif
  end

  assign bus.rs1_data    = rs1_data;
  assign bus.rs2_data    = rs2_data;
  assign bus.wb_data     = wb_data;
  assign bus.wb_commit   = wb_commit;
  assign bus.instret     = instret_q;
  assign bus.illegal_src = illegal_src_q;

endmodule

// File: tb/tb_wb_regfile_writeback.sv
// Directed bench for wb_regfile_writeback; expected values are hand-computed constants.
// Build with or without WB_WRITE_THROUGH_EN; the same-cycle read expectation follows the macro.
module tb_wb_regfile_writeback;

  localparam int XLEN  = 32;
  localparam int CNT_W = 64;

  logic clk;
  logic reset_n;

  wb_regfile_writeback_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  wb_regfile_writeback #(.XLEN(XLEN), .NREGS(32), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic drive_idle();
    bus.stall              = 1'b0;
    bus.retire_valid       = 1'b0;
    bus.ram_data           = '0;
    bus.alu_rd_result      = '0;
    bus.next_pc_data       = '0;
    bus.rd_address         = '0;
    bus.reg_write_data_src = 2'b00;
    bus.reg_write_enable   = 1'b0;
    bus.rs1_address        = '0;
    bus.rs2_address        = '0;
  endtask

  task automatic drive_op(input logic valid, input logic we, input logic [1:0] src,
                          input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] ram, input logic [31:0] pc);
    bus.retire_valid       = valid;
    bus.reg_write_enable   = we;
    bus.reg_write_data_src = src;
    bus.rd_address         = rd;
    bus.alu_rd_result      = alu;
    bus.ram_data           = ram;
    bus.next_pc_data       = pc;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.rs1_address = addr;
    bus.rs2_address = addr;
    #1;
    check_val({tag, "_rs1"}, 64'(bus.rs1_data), 64'(exp));
    check_val({tag, "_rs2"}, 64'(bus.rs2_data), 64'(exp));
  endtask

  logic [31:0] wt_exp;

  initial begin
    drive_idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // reset state: every register reads zero on both ports
    for (int i = 0; i < 32; i++) begin
      bus.rs1_address = 5'(i);
      bus.rs2_address = 5'(31 - i);
      #1;
      check_val("rst_rs1", 64'(bus.rs1_data), 64'h0);
      check_val("rst_rs2", 64'(bus.rs2_data), 64'h0);
    end
    check_val("rst_instret", bus.instret, 64'h0);
    check_val("rst_illegal", 64'(bus.illegal_src), 64'h0);

    // ALU writeback to x5
    drive_op(1'b1, 1'b1, 2'b00, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0);
    #1;
    check_val("alu_wb_data", 64'(bus.wb_data), 64'hDEADBEEF);
    check_val("alu_commit", 64'(bus.wb_commit), 64'h1);
    step();
    drive_idle();
    read_reg("alu_x5", 5'd5, 32'hDEADBEEF);
    check_val("alu_instret", bus.instret, 64'd1);

    // RAM load to x0: no commit, still retires
    drive_op(1'b1, 1'b1, 2'b01, 5'd0, 32'h0, 32'h12345678, 32'h0);
    #1;
    check_val("ram_wb_data", 64'(bus.wb_data), 64'h12345678);
    check_val("x0_commit", 64'(bus.wb_commit), 64'h0);
    step();
    drive_idle();
    read_reg("x0_read", 5'd0, 32'h0);
    check_val("x0_instret", bus.instret, 64'd2);

    // link value to x1
    drive_op(1'b1, 1'b1, 2'b10, 5'd1, 32'h0, 32'h0, 32'h104);
    #1;
    check_val("pc_wb_data", 64'(bus.wb_data), 64'h104);
    step();
    drive_idle();
    read_reg("pc_x1", 5'd1, 32'h104);
    check_val("pc_instret", bus.instret, 64'd3);

    // stall holds the slot for 3 edges
    drive_op(1'b1, 1'b1, 2'b00, 5'd7, 32'h55, 32'h0, 32'h0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("stall_commit", 64'(bus.wb_commit), 64'h0);
      step();
      bus.rs1_address = 5'd7;
      bus.rs2_address = 5'd7;
      #1;
      check_val("stall_x7", 64'(bus.rs1_data), 64'h0);
      check_val("stall_instret", bus.instret, 64'd3);
    end
    bus.stall = 1'b0;
    #1;
    check_val("unstall_commit", 64'(bus.wb_commit), 64'h1);
    step();
    drive_idle();
    read_reg("unstall_x7", 5'd7, 32'h55);
    check_val("unstall_instret", bus.instret, 64'd4);

    // bubbles do not count; a store (valid, no write) does
    repeat (3) step();
    check_val("bubble_instret", bus.instret, 64'd4);
    drive_op(1'b1, 1'b0, 2'b00, 5'd6, 32'h77, 32'h0, 32'h0);
    #1;
    check_val("store_commit", 64'(bus.wb_commit), 64'h0);
    step();
    drive_idle();
    read_reg("store_x6", 5'd6, 32'h0);
    check_val("store_instret", bus.instret, 64'd5);

    // illegal source: no write, sticky flag
    drive_op(1'b1, 1'b1, 2'b11, 5'd9, 32'h99, 32'h98, 32'h97);
    #1;
    check_val("ill_wb_data", 64'(bus.wb_data), 64'h0);
    check_val("ill_commit", 64'(bus.wb_commit), 64'h0);
    step();
    drive_idle();
    read_reg("ill_x9", 5'd9, 32'h0);
    check_val("ill_flag", 64'(bus.illegal_src), 64'h1);
    check_val("ill_instret", bus.instret, 64'd6);
    repeat (10) step();
    check_val("ill_sticky", 64'(bus.illegal_src), 64'h1);

    // same-cycle read of the register being written
    drive_op(1'b1, 1'b1, 2'b00, 5'd3, 32'h1111, 32'h0, 32'h0);
    step();
    drive_op(1'b1, 1'b1, 2'b00, 5'd3, 32'hA5A5, 32'h0, 32'h0);
    bus.rs1_address = 5'd3;
    bus.rs2_address = 5'd3;
`ifdef WB_WRITE_THROUGH_EN
    wt_exp = 32'hA5A5;
`else
    wt_exp = 32'h1111;
`endif
    #1;
    check_val("wt_rs1", 64'(bus.rs1_data), 64'(wt_exp));
    check_val("wt_rs2", 64'(bus.rs2_data), 64'(wt_exp));
    step();
    drive_idle();
    read_reg("wt_after", 5'd3, 32'hA5A5);
    check_val("wt_instret", bus.instret, 64'd8);

    // reset clears flag, counter and registers
    reset_n = 1'b0;
    drive_op(1'b1, 1'b1, 2'b00, 5'd5, 32'hFFFF, 32'h0, 32'h0);
    step();
    reset_n = 1'b1;
    drive_idle();
    check_val("rst2_illegal", 64'(bus.illegal_src), 64'h0);
    check_val("rst2_instret", bus.instret, 64'h0);
    read_reg("rst2_x5", 5'd5, 32'h0);
    read_reg("rst2_x3", 5'd3, 32'h0);

    // counter wrap from all-ones
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    release dut.instret_q;
    #1;
    check_val("wrap_preload", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
    drive_op(1'b1, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    drive_idle();
    check_val("wrap_zero", bus.instret, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
